// File: rtl/mestre_pkg.sv
// mestre_pkg: shared types for the serial bus master.
//   - status codes returned to the processor in result[DATA_W+2:DATA_W]
//   - FSM state enum (used by the top FSM and by the receiver's frame phases)
//   - largura(): counter width needed to count 0..n-1
package mestre_pkg;

  localparam logic [2:0] COD_OK             = 3'd0;
  localparam logic [2:0] COD_ALARME         = 3'd1;
  localparam logic [2:0] COD_ERRO_CHECKSUM  = 3'd2;
  localparam logic [2:0] COD_ERRO_QUADRO    = 3'd3;
  localparam logic [2:0] COD_TIMEOUT        = 3'd4;
  localparam logic [2:0] COD_SEM_RESPOSTA   = 3'd5;

  typedef enum logic [2:0] {
    ST_OK             = COD_OK,
    ST_ALARME         = COD_ALARME,
    ST_ERRO_CHECKSUM  = COD_ERRO_CHECKSUM,
    ST_ERRO_QUADRO    = COD_ERRO_QUADRO,
    ST_TIMEOUT        = COD_TIMEOUT,
    ST_SEM_RESPOSTA   = COD_SEM_RESPOSTA
  } status_t;

  typedef enum logic [3:0] {
    IDLE,
    TX_START,
    TX_DATA,
    TX_STOP,
    RX_WAIT,
    RX_START,
    RX_DATA,
    RX_STOP,
    CHECK,
    DONE
  } estado_t;

  // Bits needed for a counter that runs 0..n-1 (never less than 1).
  function automatic int largura(input int n);
    if (n <= 2) return 1;
    return $clog2(n);
  endfunction

endpackage

// File: rtl/uart_rx_quadro.sv
// uart_rx_quadro: receives one UART frame each time it is armed.
//   clk, reset      : system clock, synchronous active-low reset
//   arm             : one-cycle pulse, starts waiting for a start bit
//   rx              : asynchronous serial input (idle high)
//   valid           : one-cycle strobe, frame received with a good stop bit
//   data            : received frame, LSB first on the wire
//   erro_quadro     : one-cycle strobe, stop bit sampled low
//   timeout         : one-cycle strobe, no start bit within TIMEOUT_BITS*DIV cycles
// The strobes are decoded from registered state on the sampling cycle so
// the caller can react on the same clock edge as the sample.
module uart_rx_quadro
  import mestre_pkg::*;
#(
  parameter int DIV          = 16,
  parameter int DATA_W       = 8,
  parameter int TIMEOUT_BITS = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              arm,
  input  logic              rx,
  output logic              valid,
  output logic [DATA_W-1:0] data,
  output logic              erro_quadro,
  output logic              timeout
);

  localparam int CW = largura(DIV);
  localparam int TW = largura(TIMEOUT_BITS * DIV);
  localparam int BW = largura(DATA_W);

  localparam logic [CW-1:0] FIM_BIT    = CW'(DIV - 1);
  localparam logic [CW-1:0] MEIO_BIT   = CW'(DIV / 2 - 1);
  localparam logic [TW-1:0] FIM_ESPERA = TW'(TIMEOUT_BITS * DIV - 1);
  localparam logic [BW-1:0] ULTIMO     = BW'(DATA_W - 1);

  estado_t           r_fase;
  logic [CW-1:0]     r_cnt;
  logic [TW-1:0]     r_tcnt;
  logic [BW-1:0]     r_bit;
  logic              r_s1, r_s2, r_ant;
  logic [DATA_W-1:0] r_shift;

  logic w_borda;
  logic w_fim_stop;

  // Falling edge on the synchronised line marks a candidate start bit.
  assign w_borda    = r_ant & ~r_s2;
  assign w_fim_stop = (r_fase == RX_STOP) && (r_cnt == FIM_BIT);

  assign valid       = w_fim_stop &  r_s2;
  assign erro_quadro = w_fim_stop & ~r_s2;
  assign timeout     = (r_fase == RX_WAIT) && !w_borda && (r_tcnt == FIM_ESPERA);
  assign data        = r_shift;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_s1   <= 1'b1;
      r_s2   <= 1'b1;
      r_ant  <= 1'b1;
      r_fase <= IDLE;
      r_cnt  <= '0;
      r_tcnt <= '0;
      r_bit  <= '0;
    end else begin
      r_s1  <= rx;
      r_s2  <= r_s1;
      r_ant <= r_s2;
      unique case (r_fase)
        IDLE: begin
          if (arm) begin
            r_fase <= RX_WAIT;
            r_cnt  <= '0;
            r_tcnt <= '0;
          end
        end
        RX_WAIT: begin
          if (w_borda) begin
            r_fase <= RX_START;
            r_cnt  <= '0;
          end else if (r_tcnt == FIM_ESPERA) begin
            r_fase <= IDLE;
          end else begin
            r_tcnt <= r_tcnt + TW'(1);
          end
        end
        RX_START: begin
          // Re-sample the start bit at mid-bit; a high line means a glitch,
          // and the timeout window keeps running from where it was.
          if (r_cnt == MEIO_BIT) begin
            r_cnt <= '0;
            if (r_s2) begin
              r_fase <= RX_WAIT;
            end else begin
              r_fase <= RX_DATA;
              r_bit  <= '0;
            end
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        RX_DATA: begin
          if (r_cnt == FIM_BIT) begin
            r_cnt <= '0;
            if (r_bit == ULTIMO) r_fase <= RX_STOP;
            else                 r_bit  <= r_bit + BW'(1);
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        RX_STOP: begin
          if (r_cnt == FIM_BIT) begin
            r_cnt  <= '0;
            r_fase <= IDLE;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: r_fase <= IDLE;
      endcase
    end
  end

  // Data bits enter at the MSB so the first (LSB) bit ends up at bit 0.
  always_ff @(posedge clk) begin
    if ((r_fase == RX_DATA) && (r_cnt == FIM_BIT))
      r_shift <= {r_s2, r_shift[DATA_W-1:1]};
  end

endmodule

// File: rtl/mestre_barramento.sv
// mestre_barramento: NIOS custom-instruction serial bus master.
// Sends dataa[DATA_W-1:0] as one UART frame, then collects a two-frame
// reply (data D, check C), classifies it and returns {status, D}.
//   clk, reset : system clock, synchronous active-low reset
//   clk_en     : custom-instruction enable; start honoured only when high
//   start      : custom-instruction start
//   dataa      : command word (only the low DATA_W bits are sent)
//   rx         : serial input, idle high
//   tx         : serial output, idle high
//   result     : [DATA_W-1:0] data, [DATA_W+2:DATA_W] status, rest 0
//   done       : one-cycle pulse when result becomes valid
//   busy       : high from start acceptance through the done cycle
module mestre_barramento
  import mestre_pkg::*;
#(
  parameter int                CLK_HZ       = 50_000_000,
  parameter int                BAUD         = 9600,
  parameter int                DATA_W       = 8,
  parameter logic [DATA_W-1:0] CHAVE        = DATA_W'(8'h37),
  parameter logic [DATA_W-1:0] ALARME_DADO  = '0,
  parameter int                TIMEOUT_BITS = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk_en,
  input  logic        start,
  input  logic [31:0] dataa,
  input  logic        rx,
  output logic        tx,
  output logic [31:0] result,
  output logic        done,
  output logic        busy
);

  localparam int DIV = CLK_HZ / BAUD;
  localparam int CW  = largura(DIV);
  localparam int BW  = largura(DATA_W);

  localparam logic [CW-1:0] FIM_BIT    = CW'(DIV - 1);
  localparam logic [BW-1:0] ULTIMO_BIT = BW'(DATA_W - 1);

  function automatic status_t classificar(input logic [DATA_W-1:0] d,
                                          input logic [DATA_W-1:0] c);
    if ((d == ALARME_DADO) && (c == CHAVE)) return ST_ALARME;
    else if (c == (d ^ CHAVE))              return ST_OK;
    else                                    return ST_ERRO_CHECKSUM;
  endfunction

  function automatic logic [31:0] monta(input logic [DATA_W-1:0] d,
                                        input status_t st);
    logic [31:0] r;
    r              = '0;
    r[DATA_W-1:0]  = d;
    r[DATA_W +: 3] = st;
    return r;
  endfunction

  estado_t           r_estado;
  logic [CW-1:0]     r_cnt;
  logic [BW-1:0]     r_bit;
  logic [DATA_W-1:0] r_cmd;
  logic [DATA_W-1:0] r_txsh;
  logic [DATA_W-1:0] r_d;
  logic [DATA_W-1:0] r_c;
  logic              r_tx;
  logic              r_done;
  logic              r_busy;
  logic [31:0]       r_result;
  logic              r_arm;
  logic              r_quadro;
  logic              r_fixo;
  status_t           r_status;

  logic              w_fim_bit;
  logic              w_valid;
  logic              w_erro_quadro;
  logic              w_timeout;
  logic [DATA_W-1:0] w_dado;
  status_t           w_status;
  logic              w_unused_dataa;

  assign w_fim_bit      = (r_cnt == FIM_BIT);
  assign w_unused_dataa = &{1'b0, dataa[31:DATA_W]};

  // Error exits carry a pre-decided status; only a complete reply is classified.
  assign w_status = r_fixo ? r_status : classificar(r_d, r_c);

  assign tx     = r_tx;
  assign result = r_result;
  assign done   = r_done;
  assign busy   = r_busy;

  uart_rx_quadro #(
    .DIV          (DIV),
    .DATA_W       (DATA_W),
    .TIMEOUT_BITS (TIMEOUT_BITS)
  ) u_rx (
    .clk         (clk),
    .reset       (reset),
    .arm         (r_arm),
    .rx          (rx),
    .valid       (w_valid),
    .data        (w_dado),
    .erro_quadro (w_erro_quadro),
    .timeout     (w_timeout)
  );

  // Every terminating path goes through CHECK, so done always lands two
  // cycles after the event that ended the transaction.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_estado <= IDLE;
      r_cnt    <= '0;
      r_bit    <= '0;
      r_tx     <= 1'b1;
      r_done   <= 1'b0;
      r_busy   <= 1'b0;
      r_result <= '0;
      r_arm    <= 1'b0;
      r_quadro <= 1'b0;
      r_fixo   <= 1'b0;
      r_status <= ST_OK;
    end else begin
      r_arm  <= 1'b0;
      r_done <= 1'b0;
      unique case (r_estado)
        IDLE: begin
          r_cnt <= '0;
          if (start && clk_en) begin
            r_cmd    <= dataa[DATA_W-1:0];
            r_txsh   <= dataa[DATA_W-1:0];
            r_busy   <= 1'b1;
            r_result <= '0;
            r_tx     <= 1'b0;
            r_estado <= TX_START;
          end
        end
        TX_START: begin
          if (w_fim_bit) begin
            r_cnt    <= '0;
            r_tx     <= r_txsh[0];
            r_txsh   <= r_txsh >> 1;
            r_bit    <= '0;
            r_estado <= TX_DATA;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        TX_DATA: begin
          if (w_fim_bit) begin
            r_cnt <= '0;
            if (r_bit == ULTIMO_BIT) begin
              r_tx     <= 1'b1;
              r_estado <= TX_STOP;
            end else begin
              r_bit  <= r_bit + BW'(1);
              r_tx   <= r_txsh[0];
              r_txsh <= r_txsh >> 1;
            end
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        TX_STOP: begin
          if (w_fim_bit) begin
            r_cnt <= '0;
            if (r_cmd == '0) begin
              r_d      <= '0;
              r_status <= ST_SEM_RESPOSTA;
              r_fixo   <= 1'b1;
              r_estado <= CHECK;
            end else begin
              r_arm    <= 1'b1;
              r_quadro <= 1'b0;
              r_fixo   <= 1'b0;
              r_estado <= RX_WAIT;
            end
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        RX_WAIT: begin
          // The receiver walks the frame phases; the top only waits for its strobes.
          if (w_timeout) begin
            r_d      <= '0;
            r_status <= ST_TIMEOUT;
            r_fixo   <= 1'b1;
            r_estado <= CHECK;
          end else if (w_erro_quadro) begin
            r_d      <= w_dado;
            r_status <= ST_ERRO_QUADRO;
            r_fixo   <= 1'b1;
            r_estado <= CHECK;
          end else if (w_valid) begin
            if (!r_quadro) begin
              r_d      <= w_dado;
              r_quadro <= 1'b1;
              r_arm    <= 1'b1;
            end else begin
              r_c      <= w_dado;
              r_fixo   <= 1'b0;
              r_estado <= CHECK;
            end
          end
        end
        CHECK: begin
          r_result <= monta(r_d, w_status);
          r_done   <= 1'b1;
          r_estado <= DONE;
        end
        DONE: begin
          r_busy   <= 1'b0;
          r_estado <= IDLE;
        end
        default: r_estado <= IDLE;
      endcase
    end
  end

endmodule
